// File: rtl/sa_pkg.sv
// sa_pkg: shared types and helpers for the output-stationary systolic tile.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sa_pkg;

   // Tile control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } sa_state_t;

   // Wide signed container for the saturation helper. It covers any
   // accumulator this tile can build (2*D_W + K_W well below 128).
   localparam int SAT_W = 128;
   typedef logic signed [SAT_W-1:0] sat_t;

   // Accumulator width: full-precision product plus headroom for K_MAX terms.
   function automatic int acc_w(input int d_w, input int k_max);
      return 2 * d_w + $clog2(k_max + 1);
   endfunction

   // Drop 'frac' fraction bits (arithmetic shift, so rounding is toward
   // minus infinity) and clamp into the signed d_w-bit range. The caller
   // keeps the low d_w bits of the returned value.
   function automatic sat_t sat_shift(input sat_t acc, input int frac, input int d_w);
      sat_t w_sh;
      sat_t w_hi;
      sat_t w_lo;
      w_sh = acc >>> frac;
      w_hi = (sat_t'(1) <<< (d_w - 1)) - sat_t'(1);
      w_lo = -(sat_t'(1) <<< (d_w - 1));
      if (w_sh > w_hi) begin
         return w_hi;
      end else if (w_sh < w_lo) begin
         return w_lo;
      end else begin
         return w_sh;
      end
   endfunction

endpackage

// File: rtl/sa_os_pe.sv
// sa_os_pe: one output-stationary MAC cell; passes x right and w down.
// Latency: operands and their valids re-emerge one cycle later; acc updates on the same edge.
// Backpressure: none; the cell never stalls, bubbles are carried as valid=0.
module sa_os_pe #(
   parameter int D_W   = 16,
   parameter int ACC_W = 39
) (
   input  logic                    I_CLK,
   input  logic                    I_RST,
   input  logic                    I_CLR,
   input  logic signed [D_W-1:0]   I_X,
   input  logic                    I_X_VLD,
   input  logic signed [D_W-1:0]   I_W,
   input  logic                    I_W_VLD,
   output logic signed [D_W-1:0]   O_X,
   output logic                    O_X_VLD,
   output logic signed [D_W-1:0]   O_W,
   output logic                    O_W_VLD,
   output logic signed [ACC_W-1:0] O_ACC
);

   logic signed [2*D_W-1:0] w_prod;
   logic signed [D_W-1:0]   r_x;
   logic signed [D_W-1:0]   r_w;
   logic                    r_x_vld;
   logic                    r_w_vld;
   logic signed [ACC_W-1:0] r_acc;

   // Full-precision signed product, never truncated before accumulation
   assign w_prod = I_X * I_W;

   // Forward operands one hop and accumulate only when both operands are real beats
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_x     <= '0;
         r_w     <= '0;
         r_x_vld <= 1'b0;
         r_w_vld <= 1'b0;
         r_acc   <= '0;
      end else if (I_CLR) begin
         r_x     <= '0;
         r_w     <= '0;
         r_x_vld <= 1'b0;
         r_w_vld <= 1'b0;
         r_acc   <= '0;
      end else begin
         r_x     <= I_X;
         r_w     <= I_W;
         r_x_vld <= I_X_VLD;
         r_w_vld <= I_W_VLD;
         if (I_X_VLD && I_W_VLD) begin
            r_acc <= r_acc + ACC_W'(w_prod);
         end
      end
   end

   assign O_X     = r_x;
   assign O_X_VLD = r_x_vld;
   assign O_W     = r_w;
   assign O_W_VLD = r_w_vld;
   assign O_ACC   = r_acc;

endmodule

// File: rtl/sa_os_tile.sv
// sa_os_tile: SA_R x SA_C output-stationary systolic matmul with input skew and saturating output.
// Latency: start-to-done = K + SA_R + SA_C + 1 cycles, plus one per input bubble.
// Backpressure: O_X_RDY high only in LOAD; I_X_VLD low inserts a bubble that the array ignores.
module sa_os_tile
   import sa_pkg::*;
#(
   parameter int D_W   = 16,
   parameter int FRAC  = 13,
   parameter int SA_R  = 8,
   parameter int SA_C  = 8,
   parameter int K_MAX = 64,
   parameter int K_W   = $clog2(K_MAX + 1)
) (
   input  logic                       I_CLK,
   input  logic                       I_RST,
   input  logic                       I_START,
   input  logic [K_W-1:0]             I_K,
   input  logic                       I_X_VLD,
   input  logic [SA_R*D_W-1:0]        I_X,
   input  logic [SA_C*D_W-1:0]        I_W,
   output logic                       O_X_RDY,
   output logic                       O_BUSY,
   output logic                       O_DONE,
   output logic                       O_OUT_VLD,
   output logic [SA_R*SA_C*D_W-1:0]   O_OUT
);

   // Packing: I_X[i] at bits i*D_W, I_W[j] at j*D_W, O_OUT[i][j] at (i*SA_C+j)*D_W.

   localparam int             ACC_W   = acc_w(D_W, K_MAX);
   localparam int             FL_W    = $clog2(SA_R + SA_C + 1);
   // The skew adds one register on every lane (row 0 included), so the last
   // product lands in the far-corner PE SA_R+SA_C-1 cycles after the last
   // beat; flushing SA_R+SA_C cycles leaves the DONE cycle a settled value.
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(SA_R + SA_C - 1);
   localparam logic [K_W-1:0]  K_CAP   = K_W'(K_MAX);

   sa_state_t                r_state;
   sa_state_t                w_state_nxt;
   logic [K_W-1:0]           w_k_in;
   logic [K_W-1:0]           r_k;
   logic [K_W-1:0]           r_beat;
   logic [FL_W-1:0]          r_flush;
   logic                     w_start;
   logic                     w_x_rdy;
   logic                     w_beat;
   logic                     r_done;
   logic                     r_out_vld;
   logic [SA_R*SA_C*D_W-1:0] r_out;
   logic [SA_R*SA_C*D_W-1:0] w_out_nxt;

   // Systolic grid interconnect: x flows along rows, w flows down columns
   logic signed [D_W-1:0]    w_xg [SA_R][SA_C+1];
   logic                     w_xv [SA_R][SA_C+1];
   logic signed [D_W-1:0]    w_wg [SA_R+1][SA_C];
   logic                     w_wv [SA_R+1][SA_C];
   logic signed [ACC_W-1:0]  w_acc [SA_R][SA_C];
   // Operands leaving the array edge are dropped
   logic [D_W:0]             w_edge_x_unused [SA_R];
   logic [D_W:0]             w_edge_w_unused [SA_C];

   // Requested depth clamped to what the accumulator was sized for
   assign w_k_in = (I_K > K_CAP) ? K_CAP : I_K;

   // State register
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_x_rdy     = 1'b0;
      case (r_state)
         IDLE: begin
            if (I_START) begin
               w_start     = 1'b1;
               w_state_nxt = (w_k_in == '0) ? FLUSH : LOAD;
            end
         end
         LOAD: begin
            w_x_rdy = 1'b1;
            if (I_X_VLD && ((r_beat + K_W'(1)) == r_k)) begin
               w_state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (r_flush == FL_LAST) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_beat = w_x_rdy & I_X_VLD;

   // Depth latch, beat counter and flush counter
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_k     <= '0;
         r_beat  <= '0;
         r_flush <= '0;
      end else begin
         if (w_start) begin
            r_k    <= w_k_in;
            r_beat <= '0;
         end else if (w_beat) begin
            r_beat <= r_beat + K_W'(1);
         end
         if (r_state == FLUSH) begin
            r_flush <= r_flush + FL_W'(1);
         end else begin
            r_flush <= '0;
         end
      end
   end

   // Result register: captured on the DONE cycle, held until the next start
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_done    <= 1'b0;
         r_out_vld <= 1'b0;
         r_out     <= '0;
      end else begin
         r_done <= (r_state == DONE);
         if (w_start) begin
            r_out_vld <= 1'b0;
         end else if (r_state == DONE) begin
            r_out_vld <= 1'b1;
            r_out     <= w_out_nxt;
         end
      end
   end

   genvar gi, gj;

   // Row skew: row i is delayed i+1 cycles, valid travels with the data
   for (gi = 0; gi < SA_R; gi++) begin : g_xskew
      logic signed [D_W-1:0] r_sx [0:gi];
      logic                  r_sv [0:gi];
      // Shift chain, cleared whenever a new operation starts
      always_ff @(posedge I_CLK or posedge I_RST) begin
         if (I_RST) begin
            for (int s = 0; s <= gi; s++) begin
               r_sx[s] <= '0;
               r_sv[s] <= 1'b0;
            end
         end else if (w_start) begin
            for (int s = 0; s <= gi; s++) begin
               r_sx[s] <= '0;
               r_sv[s] <= 1'b0;
            end
         end else begin
            r_sx[0] <= I_X[gi*D_W +: D_W];
            r_sv[0] <= w_beat;
            for (int s = 1; s <= gi; s++) begin
               r_sx[s] <= r_sx[s-1];
               r_sv[s] <= r_sv[s-1];
            end
         end
      end
      assign w_xg[gi][0]        = r_sx[gi];
      assign w_xv[gi][0]        = r_sv[gi];
      assign w_edge_x_unused[gi] = {w_xv[gi][SA_C], w_xg[gi][SA_C]};
   end

   // Column skew: column j is delayed j+1 cycles, valid travels with the data
   for (gj = 0; gj < SA_C; gj++) begin : g_wskew
      logic signed [D_W-1:0] r_sw [0:gj];
      logic                  r_sv [0:gj];
      // Shift chain, cleared whenever a new operation starts
      always_ff @(posedge I_CLK or posedge I_RST) begin
         if (I_RST) begin
            for (int s = 0; s <= gj; s++) begin
               r_sw[s] <= '0;
               r_sv[s] <= 1'b0;
            end
         end else if (w_start) begin
            for (int s = 0; s <= gj; s++) begin
               r_sw[s] <= '0;
               r_sv[s] <= 1'b0;
            end
         end else begin
            r_sw[0] <= I_W[gj*D_W +: D_W];
            r_sv[0] <= w_beat;
            for (int s = 1; s <= gj; s++) begin
               r_sw[s] <= r_sw[s-1];
               r_sv[s] <= r_sv[s-1];
            end
         end
      end
      assign w_wg[0][gj]         = r_sw[gj];
      assign w_wv[0][gj]         = r_sv[gj];
      assign w_edge_w_unused[gj] = {w_wv[SA_R][gj], w_wg[SA_R][gj]};
   end

   // PE grid plus per-cell output scaling
   for (gi = 0; gi < SA_R; gi++) begin : g_row
      for (gj = 0; gj < SA_C; gj++) begin : g_col
         sa_os_pe #(
            .D_W   (D_W),
            .ACC_W (ACC_W)
         ) u_pe (
            .I_CLK   (I_CLK),
            .I_RST   (I_RST),
            .I_CLR   (w_start),
            .I_X     (w_xg[gi][gj]),
            .I_X_VLD (w_xv[gi][gj]),
            .I_W     (w_wg[gi][gj]),
            .I_W_VLD (w_wv[gi][gj]),
            .O_X     (w_xg[gi][gj+1]),
            .O_X_VLD (w_xv[gi][gj+1]),
            .O_W     (w_wg[gi+1][gj]),
            .O_W_VLD (w_wv[gi+1][gj]),
            .O_ACC   (w_acc[gi][gj])
         );
         assign w_out_nxt[(gi*SA_C+gj)*D_W +: D_W] =
            D_W'(sat_shift(sat_t'(w_acc[gi][gj]), FRAC, D_W));
      end
   end

   assign O_X_RDY   = w_x_rdy;
   assign O_BUSY    = (r_state != IDLE);
   assign O_DONE    = r_done;
   assign O_OUT_VLD = r_out_vld;
   assign O_OUT     = r_out;

endmodule

// File: tb/tb_sa_os_tile.sv
// tb_sa_os_tile: directed self-checking bench for a 4x4 sa_os_tile (Q2.13 operands).
// Latency: results and O_DONE timing checked against hand-computed values.
// Backpressure: exercises input bubbles and a start request issued during LOAD.
module tb_sa_os_tile;

   localparam int D_W = 16;
   localparam int R   = 4;
   localparam int C   = 4;
   localparam int KW  = 7;

   logic             clk;
   logic             I_RST;
   logic             I_START;
   logic [KW-1:0]    I_K;
   logic             I_X_VLD;
   logic [R*D_W-1:0] I_X;
   logic [C*D_W-1:0] I_W;
   logic             O_X_RDY;
   logic             O_BUSY;
   logic             O_DONE;
   logic             O_OUT_VLD;
   logic [R*C*D_W-1:0] O_OUT;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] a_m   [R][64];
   logic [15:0] b_m   [64][C];
   logic [15:0] exp_c [R][C];

   sa_os_tile #(
      .D_W   (16),
      .FRAC  (13),
      .SA_R  (R),
      .SA_C  (C),
      .K_MAX (64)
   ) dut (
      .I_CLK     (clk),
      .I_RST     (I_RST),
      .I_START   (I_START),
      .I_K       (I_K),
      .I_X_VLD   (I_X_VLD),
      .I_X       (I_X),
      .I_W       (I_W),
      .O_X_RDY   (O_X_RDY),
      .O_BUSY    (O_BUSY),
      .O_DONE    (O_DONE),
      .O_OUT_VLD (O_OUT_VLD),
      .O_OUT     (O_OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            chk($sformatf("%s_out[%0d][%0d]", tag, i, j),
                64'(O_OUT[(i*C+j)*D_W +: D_W]), 64'(exp_c[i][j]));
         end
      end
   endtask

   task automatic fill_a_ident();
      for (int i = 0; i < R; i++)
         for (int k = 0; k < 64; k++)
            a_m[i][k] = (i == k) ? 16'h2000 : 16'h0000;
   endtask

   task automatic fill_a_const(input logic [15:0] v);
      for (int i = 0; i < R; i++)
         for (int k = 0; k < 64; k++)
            a_m[i][k] = v;
   endtask

   task automatic fill_b_const(input logic [15:0] v);
      for (int k = 0; k < 64; k++)
         for (int j = 0; j < C; j++)
            b_m[k][j] = v;
   endtask

   task automatic set_exp_const(input logic [15:0] v);
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++)
            exp_c[i][j] = v;
   endtask

   task automatic drive_beat(input int kk);
      for (int i = 0; i < R; i++) I_X[i*D_W +: D_W] = a_m[i][kk];
      for (int j = 0; j < C; j++) I_W[j*D_W +: D_W] = b_m[kk][j];
   endtask

   // One complete operation; entered and left at posedge+1
   task automatic run_op(input logic [KW-1:0] k_in, input int n_beats, input bit bubbles,
                         input bit poke, input int exp_lat, input string tag);
      int  kk;
      int  cyc;
      bit  vld;
      kk  = 0;
      cyc = 0;
      I_START = 1'b1;
      I_K     = k_in;
      @(posedge clk);
      #1;
      I_START = 1'b0;
      chk({tag, "_busy"}, 64'(O_BUSY), 64'd1);
      chk({tag, "_rdy_start"}, 64'(O_X_RDY), 64'(n_beats > 0));
      chk({tag, "_vld_drop"}, 64'(O_OUT_VLD), 64'd0);
      while (cyc < 300) begin
         vld = (kk < n_beats) && !(bubbles && (cyc % 2 == 0));
         I_X_VLD = vld;
         if (vld) begin
            drive_beat(kk);
            chk({tag, "_rdy"}, 64'(O_X_RDY), 64'd1);
         end else begin
            I_X = {$urandom, $urandom};
            I_W = {$urandom, $urandom};
         end
         if (poke && cyc == 1) begin
            I_START = 1'b1;
            I_K     = 7'd2;
         end
         @(posedge clk);
         cyc++;
         if (vld) kk++;
         #1;
         I_START = 1'b0;
         I_X_VLD = 1'b0;
         if (O_DONE) break;
      end
      chk({tag, "_done"}, 64'(O_DONE), 64'd1);
      chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      chk({tag, "_outvld"}, 64'(O_OUT_VLD), 64'd1);
      check_out(tag);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 64'(O_DONE), 64'd0);
      chk({tag, "_hold"}, 64'(O_OUT_VLD), 64'd1);
   endtask

   initial begin
      int n_done;
      I_RST   = 1'b1;
      I_START = 1'b0;
      I_K     = '0;
      I_X_VLD = 1'b0;
      I_X     = '0;
      I_W     = '0;

      // Reset with random inputs toggling
      repeat (3) begin
         @(posedge clk);
         #1;
         I_START = 1'($urandom);
         I_K     = KW'($urandom);
         I_X_VLD = 1'($urandom);
         I_X     = {$urandom, $urandom};
         I_W     = {$urandom, $urandom};
      end
      chk("rst_rdy", 64'(O_X_RDY), 64'd0);
      chk("rst_busy", 64'(O_BUSY), 64'd0);
      chk("rst_done", 64'(O_DONE), 64'd0);
      chk("rst_vld", 64'(O_OUT_VLD), 64'd0);
      set_exp_const(16'h0000);
      check_out("rst");
      I_START = 1'b0;
      I_X_VLD = 1'b0;
      I_RST   = 1'b0;
      @(posedge clk);
      #1;

      // Identity A, B = 0.5 everywhere
      fill_a_ident();
      fill_b_const(16'h1000);
      set_exp_const(16'h1000);
      run_op(7'd4, 4, 1'b0, 1'b0, 13, "ident");

      // 1.0 * 3.0 over 4 terms = 12.0, clamps high
      fill_a_const(16'h2000);
      fill_b_const(16'h6000);
      set_exp_const(16'h7FFF);
      run_op(7'd4, 4, 1'b0, 1'b0, 13, "sat_hi");

      // 1.0 * -3.0 over 4 terms = -12.0, clamps low
      fill_b_const(16'hA000);
      set_exp_const(16'h8000);
      run_op(7'd4, 4, 1'b0, 1'b0, 13, "sat_lo");

      // Identity run with a bubble before every beat: 4 extra cycles
      fill_a_ident();
      fill_b_const(16'h1000);
      set_exp_const(16'h1000);
      run_op(7'd4, 4, 1'b1, 1'b0, 17, "bubble");

      // Identity A, distinct B entries: C must equal B position by position
      for (int k = 0; k < 64; k++)
         for (int j = 0; j < C; j++)
            b_m[k][j] = 16'((k * C + j + 1) * 16'h0100);
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++)
            exp_c[i][j] = 16'((i * C + j + 1) * 16'h0100);
      run_op(7'd4, 4, 1'b0, 1'b0, 13, "route");

      // K=1: 2^-13 * -0.5 = -2^-14, truncates toward minus infinity to -1 LSB
      fill_a_const(16'h0001);
      fill_b_const(16'hF000);
      set_exp_const(16'hFFFF);
      run_op(7'd1, 1, 1'b0, 1'b0, 10, "trunc");

      // K=0: straight to flush, zero result
      set_exp_const(16'h0000);
      run_op(7'd0, 0, 1'b0, 1'b0, 9, "k0");

      // Start request during LOAD must be ignored
      fill_a_ident();
      fill_b_const(16'h1000);
      set_exp_const(16'h1000);
      run_op(7'd4, 4, 1'b0, 1'b1, 13, "poke");

      // I_K=100 clamps to 64: 64 * (1/32 * 1.0) = 2.0
      fill_a_const(16'h0100);
      fill_b_const(16'h2000);
      set_exp_const(16'h4000);
      run_op(7'd100, 64, 1'b0, 1'b0, 73, "clamp");

      // Reset in the middle of LOAD aborts with no O_DONE
      fill_a_ident();
      fill_b_const(16'h1000);
      I_START = 1'b1;
      I_K     = 7'd4;
      @(posedge clk);
      #1;
      I_START = 1'b0;
      for (int kk = 0; kk < 2; kk++) begin
         I_X_VLD = 1'b1;
         drive_beat(kk);
         @(posedge clk);
         #1;
      end
      I_X_VLD = 1'b0;
      I_RST   = 1'b1;
      #1;
      chk("midrst_busy", 64'(O_BUSY), 64'd0);
      chk("midrst_rdy", 64'(O_X_RDY), 64'd0);
      chk("midrst_vld", 64'(O_OUT_VLD), 64'd0);
      chk("midrst_done", 64'(O_DONE), 64'd0);
      set_exp_const(16'h0000);
      check_out("midrst");
      @(posedge clk);
      #1;
      I_RST  = 1'b0;
      n_done = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (O_DONE) n_done++;
      end
      chk("midrst_nodone", 64'(n_done), 64'd0);

      // Clean identity run after the abort
      set_exp_const(16'h1000);
      run_op(7'd4, 4, 1'b0, 1'b0, 13, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
